// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - Two-stage DVI/HDMI TMDS 8b/10b encoder with running disparity.
// Optional input register stage enabled by defining TMDS_ENCODER_IN_REG_EN.
module tmds_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       vde_i,
    input  logic       c0_i,
    input  logic       c1_i,
    output logic [9:0] tmds_o
);

    logic [7:0] d_s;
    logic       vde_s;
    logic       c0_s;
    logic       c1_s;

`ifdef TMDS_ENCODER_IN_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            d_s   <= '0;
            vde_s <= 1'b0;
            c0_s  <= 1'b0;
            c1_s  <= 1'b0;
        end else begin
            d_s   <= data_i;
            vde_s <= vde_i;
            c0_s  <= c0_i;
            c1_s  <= c1_i;
        end
    end
`else
    assign d_s   = data_i;
    assign vde_s = vde_i;
    assign c0_s  = c0_i;
    assign c1_s  = c1_i;
`endif

    logic [3:0] n1d;
    logic       xnor_mode;
    logic [8:0] q_m_d;
    logic       acc;

    // Transition-minimising stage: chain XOR or XNOR across the byte
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, d_s[i]};
        end
        xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !d_s[0]);
        acc       = d_s[0];
        q_m_d     = '0;
        q_m_d[0]  = d_s[0];
        for (int i = 1; i < 8; i++) begin
            acc      = xnor_mode ? ~(acc ^ d_s[i]) : (acc ^ d_s[i]);
            q_m_d[i] = acc;
        end
        q_m_d[8] = ~xnor_mode;
    end

    logic [8:0] q_m;
    logic       vde_r;
    logic       c0_r;
    logic       c1_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_m   <= '0;
            vde_r <= 1'b0;
            c0_r  <= 1'b0;
            c1_r  <= 1'b0;
        end else begin
            q_m   <= q_m_d;
            vde_r <= vde_s;
            c0_r  <= c0_s;
            c1_r  <= c1_s;
        end
    end

    logic signed [4:0] cnt;
    logic signed [4:0] cnt_d;
    logic signed [4:0] n1q;
    logic signed [4:0] n0q;
    logic signed [4:0] diff;
    logic        [9:0] tmds_d;

    // DC-balancing stage: invert or pass the byte to steer cnt toward zero
    always_comb begin
        n1q = '0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + {4'b0000, q_m[i]};
        end
        n0q    = 5'sd8 - n1q;
        diff   = n1q - n0q;
        tmds_d = 10'h354;
        cnt_d  = 5'sd0;
        if (vde_r) begin
            if ((cnt == 5'sd0) || (n1q == n0q)) begin
                tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                cnt_d  = q_m[8] ? (cnt + diff) : (cnt - diff);
            end else if (((cnt > 5'sd0) && (n1q > n0q)) || ((cnt < 5'sd0) && (n0q > n1q))) begin
                tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
                cnt_d  = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                tmds_d = {1'b0, q_m[8], q_m[7:0]};
                cnt_d  = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
            end
        end else begin
            case ({c1_r, c0_r})
                2'b00:   tmds_d = 10'h354;
                2'b01:   tmds_d = 10'h0AB;
                2'b10:   tmds_d = 10'h154;
                default: tmds_d = 10'h2AB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmds_o <= 10'h354;
            cnt    <= 5'sd0;
        end else begin
            tmds_o <= tmds_d;
            cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - Scoreboard bench for tmds_encoder, both latency builds.
module tb_tmds_encoder;

`ifdef TMDS_ENCODER_IN_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = '0;
    logic       vde_i = 1'b0;
    logic       c0_i = 1'b0;
    logic       c1_i = 1'b0;
    logic [9:0] tmds_o;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;

    typedef struct {
        logic [9:0] sym;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    tmds_encoder dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .vde_i  (vde_i),
        .c0_i   (c0_i),
        .c1_i   (c1_i),
        .tmds_o (tmds_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model(input logic [7:0] d, input logic vde, input logic c1, input logic c0);
        int         n1d;
        int         n1q;
        int         n0q;
        logic [8:0] qm;
        logic       x;
        logic [9:0] sym;
        if (!vde) begin
            model_cnt = 0;
            case ({c1, c0})
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            return sym;
        end
        n1d   = $countones(d);
        x     = (n1d > 4) || (n1d == 4 && !d[0]);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !x;
        n1q   = $countones(qm[7:0]);
        n0q   = 8 - n1q;
        if (model_cnt == 0 || n1q == n0q) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                model_cnt += n1q - n0q;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                model_cnt += n0q - n1q;
            end
        end else if ((model_cnt > 0 && n1q > n0q) || (model_cnt < 0 && n0q > n1q)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            model_cnt += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            model_cnt += n1q - n0q - (qm[8] ? 0 : 2);
        end
        return sym;
    endfunction

    task automatic drive(input logic [7:0] d, input logic vde, input logic c1, input logic c0);
        exp_t e;
        data_i = d;
        vde_i  = vde;
        c1_i   = c1;
        c0_i   = c0;
        e.sym  = model(d, vde, c1, c0);
        e.cnt  = model_cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        model_cnt = 0;
        for (int i = 0; i < LAT - 1; i++) sb.push_back('{10'h354, 0});
        rst = 1'b0;
    endtask

    // Scoreboard: each negedge compares the oldest symbol that has reached tmds_o
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb.size() >= LAT) begin
            e = sb.pop_front();
            checks++;
            if (tmds_o !== e.sym) begin
                errors++;
                $display("FAIL sb_tmds: got %h expected %h", tmds_o, e.sym);
            end
            checks++;
            if (int'(dut.cnt) !== e.cnt || dut.cnt > 5'sd8 || dut.cnt < -5'sd8) begin
                errors++;
                $display("FAIL sb_cnt: got %0d expected %0d (range -8..8)", dut.cnt, e.cnt);
            end
        end
    end

    task automatic test_reset();
        data_i = 8'hA5;
        vde_i  = 1'b1;
        c0_i   = 1'b1;
        c1_i   = 1'b1;
        rst    = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tmds_o !== 10'h354) begin
            errors++;
            $display("FAIL reset_tmds: got %h expected 354", tmds_o);
        end
        checks++;
        if (dut.cnt !== 5'sd0 || dut.vde_r !== 1'b0 || dut.c0_r !== 1'b0 || dut.c1_r !== 1'b0 || dut.q_m !== 9'h0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d vde=%b c=%b%b q_m=%h expected 0", dut.cnt, dut.vde_r, dut.c1_r, dut.c0_r, dut.q_m);
        end
        #1;
        apply_reset();
    endtask

    task automatic test_control();
        logic [9:0] syms[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        apply_reset();
        for (int j = 0; j < 4 + LAT - 1; j++) begin
            drive(8'h00, 1'b0, j >= 2 ? 1'b1 : 1'b0, (j >= 3 || j == 1) ? 1'b1 : 1'b0);
            checks++;
            if (tmds_o !== (j < LAT - 1 ? 10'h354 : syms[j-LAT+1])) begin
                errors++;
                $display("FAIL control[%0d]: got %h expected %h", j, tmds_o, j < LAT - 1 ? 10'h354 : syms[j-LAT+1]);
            end
        end
    endtask

    task automatic test_zero_then_ctrl();
        logic [9:0] syms[6] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h0AB, 10'h100};
        int         cnts[6] = '{-8, 2, -6, 4, 0, -8};
        apply_reset();
        for (int j = 0; j < 6 + LAT - 1; j++) begin
            drive(8'h00, (j == 4 || j >= 6) ? 1'b0 : 1'b1, 1'b0, j == 4 ? 1'b1 : 1'b0);
            if (j >= LAT - 1 && j - LAT + 1 < 6) begin
                checks++;
                if (tmds_o !== syms[j-LAT+1] || int'(dut.cnt) !== cnts[j-LAT+1]) begin
                    errors++;
                    $display("FAIL zeros[%0d]: got %h cnt %0d expected %h cnt %0d", j, tmds_o, dut.cnt, syms[j-LAT+1], cnts[j-LAT+1]);
                end
            end
        end
    endtask

    task automatic test_ff();
        apply_reset();
        for (int j = 0; j < LAT; j++) begin
            drive(8'hFF, j == 0 ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (tmds_o !== 10'h200 || dut.cnt !== -5'sd8) begin
            errors++;
            $display("FAIL ff: got %h cnt %0d expected 200 cnt -8", tmds_o, dut.cnt);
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        data_i = 8'h5A;
        vde_i  = 1'b1;
        c0_i   = 1'b1;
        c1_i   = 1'b0;
        rst    = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tmds_o !== 10'h354 || dut.cnt !== 5'sd0) begin
            errors++;
            $display("FAIL midreset: got %h cnt %0d expected 354 cnt 0", tmds_o, dut.cnt);
        end
        #1;
        model_cnt = 0;
        for (int i = 0; i < LAT - 1; i++) sb.push_back('{10'h354, 0});
        rst = 1'b0;
        for (int j = 0; j < LAT; j++) begin
            drive(8'h00, 1'b1, 1'b0, 1'b0);
            checks++;
            if (tmds_o !== (j < LAT - 1 ? 10'h354 : 10'h100)) begin
                errors++;
                $display("FAIL resume[%0d]: got %h expected %h", j, tmds_o, j < LAT - 1 ? 10'h354 : 10'h100);
            end
        end
        checks++;
        if (dut.cnt !== -5'sd8) begin
            errors++;
            $display("FAIL resume_cnt: got %0d expected -8", dut.cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 10000; i++) begin
            drive(8'($urandom), $urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < LAT; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_control();
        test_zero_then_ctrl();
        test_ff();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1: pixel clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: synchronous reset, active high.
REQ-004 Port data_i, input, 8: pixel component byte.
REQ-005 Port vde_i, input, 1: video data enable; 1 = encode data_i, 0 = encode control.
REQ-006 Port c0_i, input, 1: control bit 0, used when vde_i=0.
REQ-007 Port c1_i, input, 1: control bit 1, used when vde_i=0.
REQ-008 Port tmds_o, output, 10: registered TMDS symbol; bit 0 is transmitted first.

Function
REQ-009 Stage 1 SHALL count n1d, the number of ones in data_i.
REQ-010 Stage 1 SHALL select XNOR mode when n1d>4, or when n1d==4 and data_i[0]==0; otherwise it SHALL select XOR mode.
REQ-011 Stage 1 SHALL form the 9-bit q_m as follows: q_m[0]=d[0]; q_m[i]=q_m[i-1] XOR/XNOR d[i] for i=1..7; q_m[8]=1 in XOR mode and 0 in XNOR mode.
REQ-012 Stage 1 SHALL register q_m together with vde_i, c0_i and c1_i.
REQ-013 Stage 2 SHALL compute n1q and n0q, the counts of ones and zeros in q_m[7:0].
REQ-014 The running disparity cnt SHALL be a 5-bit signed register, with all arithmetic done at signed 5-bit width; for valid streams cnt stays within -8..+8.
REQ-015 When registered vde=1 and (cnt==0 or n1q==n0q), stage 2 SHALL output tmds={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]} and update cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
REQ-016 Otherwise, when vde=1 and ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)), stage 2 SHALL output tmds={1, q_m[8], ~q_m[7:0]} and update cnt += 2*q_m[8] + (n0q-n1q).
REQ-017 Otherwise, when vde=1, stage 2 SHALL output tmds={0, q_m[8], q_m[7:0]} and update cnt += (n1q-n0q) - 2*~q_m[8].
REQ-018 When registered vde=0, stage 2 SHALL clear cnt to 0 and output a control symbol selected by {c1,c0}: 00 -> 10'h354, 01 -> 10'h0AB, 10 -> 10'h154, 11 -> 10'h2AB.
REQ-019 Inputs sampled at rising edge N SHALL appear on tmds_o after edge N+1 (2-cycle latency) with no bubbles, accepting one input per cycle.
REQ-020 A vde_i toggle SHALL take effect on exactly the symbol whose inputs carried it, with no cycle skew between data and control paths.

Reset
REQ-021 With rst high at edge N, tmds_o SHALL be 10'h354 after edge N, cnt SHALL be 0, and the stage-1 registers SHALL hold vde=0, c0=0, c1=0, q_m=0.
REQ-022 For the first cycle after rst deasserts, tmds_o SHALL remain 10'h354, since the cleared stage 1 feeds stage 2.
REQ-023 Reset asserted mid-stream SHALL override all inputs; disparity history SHALL be discarded.

Configuration
REQ-024 When macro TMDS_ENCODER_IN_REG_EN is defined, the block SHALL add an input register on data_i, vde_i, c0_i and c1_i ahead of stage 1.
REQ-025 With TMDS_ENCODER_IN_REG_EN defined, latency SHALL be 3 cycles, the added register SHALL be reset to vde=0, c=00, data=0, and tmds_o SHALL hold 10'h354 for two cycles after reset release.
REQ-026 Without TMDS_ENCODER_IN_REG_EN, the block SHALL have no input register and latency SHALL be 2 cycles.
REQ-027 Encoding results SHALL be identical in both builds apart from the latency.

Verification
REQ-028 Release reset, hold vde_i=0, then apply {c1,c0}=00, 01, 10, 11 on consecutive cycles -> tmds_o = 354, 354, 0AB, 154, 2AB (hex), each appearing 2 cycles after its input.
REQ-029 From cnt=0, apply vde_i=1, data_i=00 for 4 cycles -> tmds_o = 100, 3FF, 100, 3FF and cnt = -8, +2, -6, +4.
REQ-030 From cnt=0, apply vde_i=1, data_i=FF -> tmds_o = 200 and cnt = -8.
REQ-031 After the REQ-029 sequence leaves cnt=+4, apply one vde_i=0 cycle with c=01, then data_i=00 -> tmds_o = 0AB, then 100.
REQ-032 Assert rst for one cycle in the middle of the REQ-029 stream, then resume data_i=00 -> tmds_o = 354, 354, then 100 (disparity restarted).
REQ-033 Drive 10k random data/vde/c inputs against a reference model -> bit-exact tmds_o match, and cnt never exceeds the range -8..+8; repeat with TMDS_ENCODER_IN_REG_EN defined, checking the 3-cycle latency.
